tick_period_meter: RTL and testbench



---
 rtl/tick_period_meter.sv | 173 +++++++++++++++++
 tb/tb_tick_period_meter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/tick_period_meter.sv
// Measures period and synchronised high time of a slow asynchronous tick, with stall timeout.
// Optional PERIOD_AVG_EN: publish the truncated average of every 4 measurements instead of each one.
module tick_period_meter #(
   parameter int CNT_W   = 25,
   parameter int TIMEOUT = 27000000
) (
   input  logic             clk_27,
   input  logic             rst,
   input  logic             sig_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             period_valid,
   output logic             locked,
   output logic             timeout
);

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      MEAS = 2'd1,
      TMO  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state, state_d;
   logic             s1, s2, s3;
   logic             rise;
   logic [CNT_W-1:0] cnt, hi_cnt;
   logic [CNT_W-1:0] meas_p;
   logic             meas_done, tmo_hit, restart;

   always_ff @(posedge clk_27 or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sig_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise   = s2 & ~s3;
   assign meas_p = cnt + CNT_W'(1);

   always_ff @(posedge clk_27 or negedge rst) begin
      if (!rst) state <= ARM;
      else      state <= state_d;
   end

   // A rise coinciding with the last allowed count is a valid measurement, not a timeout.
   always_comb begin
      state_d   = state;
      meas_done = 1'b0;
      tmo_hit   = 1'b0;
      restart   = 1'b0;
      case (state)
         ARM: begin
            if (rise) begin
               restart = 1'b1;
               state_d = MEAS;
            end
         end
         MEAS: begin
            if (rise) begin
               meas_done = 1'b1;
            end else if (cnt == TMO_LAST) begin
               tmo_hit = 1'b1;
               state_d = TMO;
            end
         end
         TMO: begin
            if (rise) begin
               restart = 1'b1;
               state_d = MEAS;
            end
         end
         default: state_d = ARM;
      endcase
   end

   // The rise cycle opens the next interval and s2 is high in it, so hi_cnt restarts at 1.
   always_ff @(posedge clk_27 or negedge rst) begin
      if (!rst) begin
         cnt    <= '0;
         hi_cnt <= '0;
      end else if (restart || meas_done) begin
         cnt    <= '0;
         hi_cnt <= CNT_W'(1);
      end else if (state == MEAS && !tmo_hit) begin
         cnt    <= cnt + CNT_W'(1);
         hi_cnt <= hi_cnt + CNT_W'(s2);
      end else begin
         cnt    <= '0;
         hi_cnt <= '0;
      end
   end

`ifdef PERIOD_AVG_EN
   logic [CNT_W+1:0] sum_p, sum_h, sum_p_nx, sum_h_nx;
   logic [1:0]       idx;

   assign sum_p_nx = sum_p + {2'b00, meas_p};
   assign sum_h_nx = sum_h + {2'b00, hi_cnt};

   always_ff @(posedge clk_27 or negedge rst) begin
      if (!rst) begin
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
         sum_p        <= '0;
         sum_h        <= '0;
         idx          <= 2'd0;
      end else begin
         period_valid <= 1'b0;
         if (meas_done) begin
            if (idx == 2'd3) begin
               period       <= sum_p_nx[CNT_W+1:2];
               high_time    <= sum_h_nx[CNT_W+1:2];
               period_valid <= 1'b1;
               locked       <= 1'b1;
               sum_p        <= '0;
               sum_h        <= '0;
               idx          <= 2'd0;
            end else begin
               sum_p <= sum_p_nx;
               sum_h <= sum_h_nx;
               idx   <= idx + 2'd1;
            end
         end
         if (tmo_hit) begin
            period    <= '0;
            high_time <= '0;
            locked    <= 1'b0;
            timeout   <= 1'b1;
            sum_p     <= '0;
            sum_h     <= '0;
            idx       <= 2'd0;
         end
         if (restart) timeout <= 1'b0;
      end
   end
`else
   always_ff @(posedge clk_27 or negedge rst) begin
      if (!rst) begin
         period       <= '0;
         high_time    <= '0;
         period_valid <= 1'b0;
         locked       <= 1'b0;
         timeout      <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         if (meas_done) begin
            period       <= meas_p;
            high_time    <= hi_cnt;
            period_valid <= 1'b1;
            locked       <= 1'b1;
         end
         if (tmo_hit) begin
            period    <= '0;
            high_time <= '0;
            locked    <= 1'b0;
            timeout   <= 1'b1;
         end
         if (restart) timeout <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: table-driven waveforms, hand-written timeout sequences and
// random waveforms, all checked every cycle against an interval-arithmetic reference model.
module tb_tick_period_meter;

   localparam int CNT_W   = 25;
   localparam int TIMEOUT = 1000;

   logic             clk_27 = 1'b0;
   logic             rst    = 1'b0;
   logic             sig_in = 1'b0;
   logic [CNT_W-1:0] period, high_time;
   logic             period_valid, locked, timeout;

   tick_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk_27       (clk_27),
      .rst          (rst),
      .sig_in       (sig_in),
      .period       (period),
      .high_time    (high_time),
      .period_valid (period_valid),
      .locked       (locked),
      .timeout      (timeout)
   );

   always #5 clk_27 = ~clk_27;

   int total = 0;
   int bad   = 0;

   // Reference model: h[k] is the input value seen at clock edge k (0 while in reset).
   bit               h[$];
   int               mode = 0;   // 0 waiting first rise, 1 measuring, 2 stalled
   int               last_r = 0;
   int               acc_n = 0;
   longint           acc_p = 0, acc_h = 0;
   logic [CNT_W-1:0] e_period = '0, e_high = '0;
   logic             e_valid = 1'b0, e_locked = 1'b0, e_timeout = 1'b0;

   int n_strobe = 0, last_p = 0, last_h = 0, lat = 0, rise_drv = 0, k_tmo = 0;
   bit saw_tmo = 1'b0;

   typedef struct {
      int hi;
      int lo;
      int reps;
      int exp_p;
      int exp_h;
   } vec_t;
   vec_t tbl[6];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic publish(input int p, input int hs);
`ifdef PERIOD_AVG_EN
      acc_p += p;
      acc_h += hs;
      acc_n++;
      if (acc_n == 4) begin
         e_period = CNT_W'(acc_p / 4);
         e_high   = CNT_W'(acc_h / 4);
         e_valid  = 1'b1;
         e_locked = 1'b1;
         acc_n = 0; acc_p = 0; acc_h = 0;
      end
`else
      e_period = CNT_W'(p);
      e_high   = CNT_W'(hs);
      e_valid  = 1'b1;
      e_locked = 1'b1;
`endif
   endtask

   // Advance the model by the clock edge just taken, then compare every output.
   task automatic step();
      int k, hs;
      bit a, b, rs;
      h.push_back(rst ? sig_in : 1'b0);
      k = h.size() - 1;
      e_valid = 1'b0;
      if (!rst) begin
         mode = 0;
         e_period = '0; e_high = '0; e_locked = 1'b0; e_timeout = 1'b0;
         acc_n = 0; acc_p = 0; acc_h = 0;
      end else begin
         a  = (k >= 2) ? h[k-2] : 1'b0;
         b  = (k >= 3) ? h[k-3] : 1'b0;
         rs = a && !b;
         case (mode)
            0: if (rs) begin mode = 1; last_r = k; end
            1: begin
               if (rs) begin
                  hs = 0;
                  for (int j = last_r; j < k; j++) hs += int'(h[j-2]);
                  publish(k - last_r, hs);
                  last_r = k;
               end else if (k - last_r == TIMEOUT) begin
                  mode = 2;
                  e_timeout = 1'b1; e_locked = 1'b0; e_period = '0; e_high = '0;
                  acc_n = 0; acc_p = 0; acc_h = 0;
               end
            end
            default: if (rs) begin mode = 1; e_timeout = 1'b0; last_r = k; end
         endcase
      end
      check("outputs", 64'({period, high_time, period_valid, locked, timeout}),
            64'({e_period, e_high, e_valid, e_locked, e_timeout}));
      if (period_valid) begin
         n_strobe++;
         last_p = int'(period);
         last_h = int'(high_time);
         lat    = k - rise_drv;
      end
      if (timeout && !saw_tmo) begin
         saw_tmo = 1'b1;
         k_tmo   = k;
      end
   endtask

   task automatic drive(input bit v, input bit r);
      @(negedge clk_27);
      step();
      if (v && !sig_in) rise_drv = h.size() - 1;
      sig_in = v;
      rst    = r;
   endtask

   task automatic wave(input int hi, input int lo, input int reps);
      repeat (reps) begin
         repeat (hi) drive(1'b1, 1'b1);
         repeat (lo) drive(1'b0, 1'b1);
      end
   endtask

   task automatic reset_dut(input int n);
      repeat (n) drive(!sig_in, 1'b0);
      drive(1'b0, 1'b1);
      n_strobe = 0;
      saw_tmo  = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, exp_n, hi, lo;
      tbl[0] = '{30, 70, 4, 100, 30};
      tbl[1] = '{1, 1, 8, 2, 1};
      tbl[2] = '{50, 50, 4, 100, 50};
      tbl[3] = '{2, 3, 8, 5, 2};
      tbl[4] = '{999, 1, 4, 1000, 999};
      tbl[5] = '{270, 270, 4, 540, 270};

      // Reset with the input toggling: nothing may come out.
      reset_dut(5);
      check("reset_no_strobe", 64'(n_strobe), 64'(0));
      check("reset_outputs", 64'({period, high_time, period_valid, locked, timeout}), 64'(0));

      foreach (tbl[i]) begin
         reset_dut(3);
         wave(tbl[i].hi, tbl[i].lo, tbl[i].reps);
         repeat (4) drive(1'b1, 1'b1);
`ifdef PERIOD_AVG_EN
         exp_n = tbl[i].reps / 4;
`else
         exp_n = tbl[i].reps;
         check("tbl_latency", 64'(lat), 64'(3));
`endif
         check("tbl_period", 64'(last_p), 64'(tbl[i].exp_p));
         check("tbl_high", 64'(last_h), 64'(tbl[i].exp_h));
         check("tbl_strobes", 64'(n_strobe), 64'(exp_n));
         check("tbl_locked", 64'(locked), 64'(1));
         check("tbl_no_timeout", 64'(saw_tmo), 64'(0));
      end

      // Stall after lock, then recover with a 100-cycle period.
      reset_dut(3);
      wave(30, 70, 5);
      drive(1'b1, 1'b1);
      for (int c = 0; c < 1200 && !saw_tmo; c++) drive(1'b0, 1'b1);
      check("timeout_seen", 64'(saw_tmo), 64'(1));
      check("timeout_delay", 64'(k_tmo - rise_drv - 3), 64'(TIMEOUT));
      check("timeout_state", 64'({locked, period, high_time}), 64'(0));
      n0 = n_strobe;
      repeat (5) drive(1'b1, 1'b1);
      check("recover_timeout_clear", 64'(timeout), 64'(0));
      check("recover_no_strobe", 64'(n_strobe), 64'(n0));
      repeat (45) drive(1'b1, 1'b1);
      repeat (50) drive(1'b0, 1'b1);
      repeat (4) drive(1'b1, 1'b1);
`ifndef PERIOD_AVG_EN
      check("recover_period", 64'(last_p), 64'(100));
      check("recover_strobes", 64'(n_strobe), 64'(n0 + 1));
`endif

      // One cycle beyond the timeout limit must stall rather than measure.
      reset_dut(3);
      wave(1, TIMEOUT, 2);
      check("boundary_timeout", 64'(saw_tmo), 64'(1));
      check("boundary_no_strobe", 64'(n_strobe), 64'(0));

      // Random waveforms with occasional stalls and mid-measurement resets.
      reset_dut(3);
      for (int i = 0; i < 30; i++) begin
         hi = $urandom_range(1, 400);
         lo = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 100, TIMEOUT + 100)
                                          : $urandom_range(1, 400);
         if ($urandom_range(0, 9) == 0) reset_dut($urandom_range(1, 3));
         wave(hi, lo, 1);
      end
      repeat (5) drive(1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
